// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared display types and constants for the 7-segment scan display.
//   seg7_t     : one glyph, bit 0 = segment a ... bit 6 = segment g
//   SEG7_OFF   : all segments dark (default polarity)
//   SEG7_OVF   : overflow glyph, segments c, d, e and f lit
//   SEG7_HEX   : hex glyph table indexed by nibble value 0..F
//   seg7_glyph : table lookup helper used by the decoder
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_OFF = 7'h00;
    localparam seg7_t SEG7_OVF = 7'h3C;

    // Lower-case b and d keep 8/B and 0/D distinguishable on the display.
    localparam seg7_t SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg7_t seg7_glyph(input logic [3:0] nib);
        return SEG7_HEX[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
// Purely combinational nibble-to-glyph decoder.
//   nibble : 4-bit hex value
//   glyph  : segment pattern {g..a}, default (active-high) polarity
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      glyph
);

    assign glyph = seg7_glyph(nibble);

endmodule

// File: rtl/seg7_adder_scan.sv
// seg7_adder_scan
// Adds two NDIG-digit hex operands on a load strobe and shows the registered
// sum on a time-multiplexed common-segment display.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   load  : single-cycle strobe, captures a + b
//   a, b  : operands, 4*NDIG bits each
//   seg   : segments, seg[0] = a ... seg[6] = g
//   an    : one-hot digit enable, an[0] = least significant digit
//   ovf   : carry-out of the last load
module seg7_adder_scan
    import seg7_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              ovf
);

    localparam int W    = 4 * NDIG;
    localparam int CNTW = $clog2(SCAN_DIV);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [6:0]      SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NDIG-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [W-1:0]      sum_q;
    logic [CNTW-1:0]   cnt;
    logic [IDXW-1:0]   idx;
    logic              cnt_last;
    logic              idx_last;

    logic [3:0]        cur_nib;
    logic              upper_zero;
    logic              digit_lz;
    seg7_t             glyph;
    logic              in_blank;
    logic              lz_hide;
    seg7_t             seg_nxt;
    logic [NDIG-1:0]   an_nxt;

    // The sum is computed one bit wider than the operands so the carry-out
    // lands in ovf. Every load overwrites the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            {ovf, sum_q} <= {1'b0, a} + {1'b0, b};
        end
    end

    assign cnt_last = (cnt == CNTW'(SCAN_DIV - 1));
    assign idx_last = (idx == IDXW'(NDIG - 1));

    // Prescaler and digit index. The scan runs freely and is independent of
    // loads, so a load never shifts a slot boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx_last ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Walk the digits from the most significant end: upper_zero stays set
    // while every nibble seen so far is zero, so when the walk reaches the
    // current digit it tells whether that digit and all above it are zero.
    always_comb begin
        cur_nib    = 4'h0;
        upper_zero = 1'b1;
        digit_lz   = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (sum_q[4*i +: 4] == 4'h0);
            if (idx == IDXW'(i)) begin
                cur_nib  = sum_q[4*i +: 4];
                digit_lz = upper_zero;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nib),
        .glyph  (glyph)
    );

    assign in_blank = (cnt < CNTW'(BLANK_CYC));

    // Digit 0 is never suppressed, and overflow must show on every digit,
    // so both override leading-zero blanking.
    assign lz_hide = (LZ_BLANK != 0) && (idx != '0) && digit_lz && !ovf;

    // Next display value in default polarity; everything dark unless the
    // slot is past its blanking interval and the digit is not suppressed.
    always_comb begin
        seg_nxt = SEG7_OFF;
        an_nxt  = '0;
        if (!in_blank && !lz_hide) begin
            for (int i = 0; i < NDIG; i++) begin
                an_nxt[i] = (idx == IDXW'(i));
            end
            seg_nxt = ovf ? SEG7_OVF : glyph;
        end
    end

    // Output registers. Polarity is applied only here so the internal logic
    // always works in active-high terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_INV;
            an  <= AN_INV;
        end else begin
            seg <= seg_nxt ^ SEG_INV;
            an  <= an_nxt ^ AN_INV;
        end
    end

endmodule

// File: tb/tb_seg7_adder_scan.sv
// tb_seg7_adder_scan
// Directed bench for seg7_adder_scan with NDIG=2, SCAN_DIV=4, BLANK_CYC=1.
// A small reference model of the scan position and sum predicts each
// registered display value, which is queued when the cycle is driven and
// compared once the DUT has clocked it out.
module tb_seg7_adder_scan;

    localparam int NDIG      = 2;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic [6:0] seg;
    logic [1:0] an;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state: scan position and sum after the latest edge.
    int         m_cnt = 0;
    int         m_idx = 0;
    logic [7:0] m_sum = 8'h00;
    logic       m_ovf = 1'b0;

    logic [8:0] sb [$];

    seg7_adder_scan #(
        .NDIG           (NDIG),
        .SCAN_DIV       (SCAN_DIV),
        .BLANK_CYC      (BLANK_CYC),
        .LZ_BLANK       (1),
        .SEG_ACTIVE_LOW (0),
        .AN_ACTIVE_LOW  (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .a     (a),
        .b     (b),
        .seg   (seg),
        .an    (an),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Hex glyph table {g..a}.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Expected {an, seg} for a given scan position and sum.
    function automatic logic [8:0] expectOut(input int cnt, input int idx,
                                             input logic [7:0] sum, input logic ov);
        logic [3:0] nib;
        logic       dark;
        nib  = (idx == 0) ? sum[3:0] : sum[7:4];
        dark = (cnt < BLANK_CYC);
        if (!ov && idx == 1 && sum[7:4] == 4'h0) dark = 1'b1;
        if (dark) return 9'h000;
        return {(idx == 0) ? 2'b01 : 2'b10, ov ? 7'h3C : glyph(nib)};
    endfunction

    task automatic checkValue(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [8:0] exp;
        if (sb.size() == 0) begin
            checkValue("scoreboard_empty", 9'h1, 9'h0);
        end else begin
            exp = sb.pop_front();
            checkValue("display", {an, seg}, exp);
        end
        checkValue("ovf", {8'h00, ovf}, {8'h00, m_ovf});
        checkValue("an_onehot", ($countones(an) <= 1) ? 9'h1 : 9'h0, 9'h1);
    endtask

    // One clock cycle: drive inputs, queue the prediction, clock, advance the
    // model, then compare one cycle-settled sample.
    task automatic applyStimulus(input logic ld, input logic [7:0] av, input logic [7:0] bv);
        load = ld;
        a    = av;
        b    = bv;
        sb.push_back(expectOut(m_cnt, m_idx, m_sum, m_ovf));
        @(posedge clk);
        if (ld) {m_ovf, m_sum} = {1'b0, av} + {1'b0, bv};
        if (m_cnt == SCAN_DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % NDIG;
        end else begin
            m_cnt++;
        end
        #1;
        load = 1'b0;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00);
    endtask

    task automatic modelReset();
        m_cnt = 0;
        m_idx = 0;
        m_sum = 8'h00;
        m_ovf = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        $display("[TB] start");
        #2;
        checkValue("reset_seg", {2'b00, seg}, 9'h000);
        checkValue("reset_an", {7'h00, an}, 9'h000);
        checkValue("reset_ovf", {8'h00, ovf}, 9'h000);
        #10;
        rst_n = 1'b1;
        modelReset();

        // First slot after release: blank cycle, then digit 0 lit.
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkValue("first_blank_an", {7'h00, an}, 9'h000);
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkValue("first_active_an", {7'h00, an}, 9'h001);
        idle(2);

        // Basic add 12 + 34 = 46.
        applyStimulus(1'b1, 8'h12, 8'h34);
        checkValue("basic_ovf", {8'h00, ovf}, 9'h000);
        idle(16);

        // Overflow FF + 01: every digit shows the overflow glyph.
        applyStimulus(1'b1, 8'hFF, 8'h01);
        checkValue("overflow_ovf", {8'h00, ovf}, 9'h001);
        idle(8);

        // Asynchronous reset in the middle of the idx 1 slot.
        for (int n = 0; n < 16 && !(m_idx == 1 && m_cnt == 2); n++) idle(1);
        checkValue("pre_reset_an", {7'h00, an}, 9'h002);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async_rst_seg", {2'b00, seg}, 9'h000);
        checkValue("async_rst_an", {7'h00, an}, 9'h000);
        checkValue("async_rst_ovf", {8'h00, ovf}, 9'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        idle(4);

        // Leading-zero blanking and hex glyphs.
        applyStimulus(1'b1, 8'h03, 8'h04);
        idle(8);
        applyStimulus(1'b1, 8'h0A, 8'h00);
        idle(8);
        applyStimulus(1'b1, 8'h00, 8'h00);
        idle(8);

        // Mid-slot reload during the active part of digit 0.
        for (int n = 0; n < 16 && !(m_idx == 0 && m_cnt == 1); n++) idle(1);
        applyStimulus(1'b1, 8'h05, 8'h21);
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkValue("reload_seg", {2'b00, seg}, 9'h07D);
        checkValue("reload_an", {7'h00, an}, 9'h001);
        idle(8);

        // Load in the cycle where idx wraps back to 0.
        for (int n = 0; n < 16 && !(m_idx == 1 && m_cnt == 3); n++) idle(1);
        applyStimulus(1'b1, 8'hC0, 8'h0B);
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_adder_scan.md
# seg7_adder_scan

Parametrised successor to the single-digit adder/7-segment decoder. Adds two NDIG-digit hex operands, holds the sum in a register, and drives a time-multiplexed common-segment display: one digit per scan slot, with an inter-digit blanking interval, optional leading-zero blanking and a carry-out overflow indication. Sits between the operand switches/bus and the board display pins.

## Interface
- NDIG, 4, number of hex digits; operand width W = 4*NDIG.
- SCAN_DIV, 50000, clock cycles per digit slot; must be at least 2.
- BLANK_CYC, 500, cycles at the start of each slot with all anodes inactive; must satisfy 1 <= BLANK_CYC < SCAN_DIV.
- LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 is never blanked).
- SEG_ACTIVE_LOW, 0, 1 = inverted polarity on seg.
- AN_ACTIVE_LOW, 0, 1 = inverted polarity on an.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- load  in  1  single-cycle strobe; samples a and b.
- a  in  W  operand A.
- b  in  W  operand B.
- seg  out  7  segments, seg[0]=a … seg[6]=g.
- an  out  NDIG  one-hot digit enable; an[0] is the least significant digit.
- ovf  out  1  registered carry-out of the last load.

## Operation
- Capture: when load=1 at a rising edge, sum_q <= a + b computed W+1 bits wide. sum_q holds the low W bits and ovf holds bit W. load is always accepted, and back-to-back loads each overwrite the previous result.
- Scan: prescaler cnt counts from 0 to SCAN_DIV-1. Digit index idx advances when cnt = SCAN_DIV-1 and wraps from NDIG-1 to 0.
- Blanking interval: while cnt < BLANK_CYC, an is all inactive and seg is all inactive.
- Active part of the slot: an[idx] is active and seg = glyph(nibble idx of sum_q).
- Leading-zero blanking: with LZ_BLANK=1 and idx != 0, digit idx is blanked when nibbles idx..NDIG-1 are all zero. A blanked digit drives both an and seg inactive.
- Overflow: when ovf=1, every digit shows the overflow glyph (segments c, d, e, f lit; 7'h3C). Overflow overrides leading-zero blanking.
- Glyphs, given as {g..a}:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
  - All 16 codes are distinct and there is no unreachable case.
- Polarity inversion is applied at the output register only.

## Timing
- Reset (asynchronous, immediate):
  - sum_q = 0, ovf = 0, cnt = 0, idx = 0.
  - seg and an at their inactive levels (all 0 with default polarity).
  - First slot after release starts at idx 0, beginning with its blanking interval.
- seg and an are registered: the output at edge t+1 reflects cnt, idx and sum_q as they were after edge t.
- Load latency: load sampled at edge k updates sum_q/ovf at edge k. seg reflects the new value from edge k+1 if the current slot is in its active part; there is no wait for a slot boundary.
- Slot period is exactly SCAN_DIV cycles. A full frame is NDIG*SCAN_DIV cycles. an is never two-hot.
- A load in the cycle where idx wraps takes effect with no dropped or duplicated slot.

## Structure
- Package seg7_pkg:
  - seg7_t (logic [6:0]).
  - Glyph constants SEG7_HEX[16] and SEG7_OVF = 7'h3C.
  - SEG7_OFF.
- Sub-module seg7_hex_decode: combinational, nibble in, seg7_t out, using the package table. This replaces the old display decoder.
- Top level contains the sum register, prescaler, idx counter, blank/LZ logic and output registers.

## Test plan
All scenarios use NDIG=2, SCAN_DIV=4, BLANK_CYC=1, LZ_BLANK=1, default polarities.
- Reset: assert rst_n=0 mid-slot with idx=1 -> seg=00, an=00 and ovf=0 in the same cycle without waiting for a clock. After release, the first active an is 01, reached at cnt=1.
- Basic add: load a=12, b=34 -> ovf=0.
  - Slot idx 0: an=01 with seg=7D for 3 cycles, then one blank cycle.
  - Slot idx 1: an=10 with seg=66.
  - The pattern repeats every 8 cycles.
- Overflow: load a=FF, b=01 -> ovf=1. Both slots show seg=3C with an active.
- Leading-zero and hex: load a=03, b=04 -> digit 0 seg=07, digit 1 an=00/seg=00.
  - Then load a=0A, b=00 -> digit 0 seg=77, digit 1 blanked.
  - Then load 00+00 -> digit 0 seg=3F.
- Mid-slot reload: load during the active part of idx 0 -> the new glyph appears on seg exactly one cycle after sum_q changes. an and the slot boundary are unaffected.
